// File: rtl/fip_pkg.sv
// Shared types and helpers for the fast-inner-product result path.
package fip_pkg;

    localparam int LANES = 12;
    localparam int PRODS = 4;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    function automatic int fip_pw(input int in_size_1);
        return 2 * (in_size_1 + 1);
    endfunction

    // Words arrive already sign-extended to 64 bits; callers truncate.
    function automatic logic [63:0] sum12(input logic [63:0] w [LANES]);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            s = s + w[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/fip_beat_sum.sv
// Combinational adder tree: 12 signed partial words to one ACC_W beat sum.
module fip_beat_sum
    import fip_pkg::*;
#(
    parameter int P_W   = 18,
    parameter int ACC_W = 32
) (
    input  logic [P_W-1:0]   words [LANES],
    output logic [ACC_W-1:0] sum
);

    logic [63:0] ext [LANES];
    logic [63:0] total;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ext[i] = 64'($signed(words[i]));
        end
    end

    assign total = sum12(ext);
    assign sum   = ACC_W'(total);

endmodule

// File: rtl/fip_result_acc.sv
// Accumulates partial-product beats and emits the Winograd-corrected
// dot product on a valid/ready port.
module fip_result_acc
    import fip_pkg::*;
#(
    parameter  int IN_SIZE_1 = 8,
    parameter  int ACC_W     = 32,
    parameter  int MAX_BEATS = 256,
    localparam int P_W       = fip_pw(IN_SIZE_1),
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [P_W-1:0]   in_data_i [LANES],
    input  logic             in_last_i,
    input  logic [ACC_W-1:0] corr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic             out_err_o
);

    state_t           state;
    logic             live;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] bsum;
    logic [ACC_W-1:0] corr_term;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             at_max;

    fip_beat_sum #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_beat_sum (
        .words (in_data_i),
        .sum   (bsum)
    );

    // Held low through reset; ready only once a clock edge has been seen.
    assign in_ready_o  = live && (state == ACC);
    assign out_valid_o = (state == OUT);
    assign accept      = in_valid_i && in_ready_o;
    assign cnt_inc     = cnt + CNT_W'(1);
    assign at_max      = (cnt_inc == CNT_W'(MAX_BEATS));
    assign corr_term   = in_last_i ? corr_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ACC;
            live       <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            out_data_o <= '0;
            out_cnt_o  <= '0;
            out_err_o  <= 1'b0;
        end else begin
            live <= 1'b1;
            unique case (state)
                ACC: begin
                    if (accept) begin
                        if (in_last_i || at_max) begin
                            out_data_o <= acc + bsum - corr_term;
                            out_cnt_o  <= cnt_inc;
                            out_err_o  <= !in_last_i;
                            acc        <= '0;
                            cnt        <= '0;
                            state      <= OUT;
                        end else begin
                            acc <= acc + bsum;
                            cnt <= cnt_inc;
                        end
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_fip_result_acc.sv
// Self-checking bench: a default instance plus a narrow/short instance
// (ACC_W=20, MAX_BEATS=4) checked against a plain-arithmetic dot product.
module tb_fip_result_acc;

    logic        clk;
    logic        rst;
    logic [17:0] din [12];
    logic        in_last;
    logic [31:0] corr;

    logic        va, ra, ova, ora, oea;
    logic [31:0] oda;
    logic [8:0]  oca;

    logic        vb, rb, ovb, orb, oeb;
    logic [19:0] odb;
    logic [2:0]  ocb;

    int n_cmp = 0;
    int n_bad = 0;

    fip_result_acc dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (va),
        .in_ready_o  (ra),
        .in_data_i   (din),
        .in_last_i   (in_last),
        .corr_i      (corr),
        .out_valid_o (ova),
        .out_ready_i (ora),
        .out_data_o  (oda),
        .out_cnt_o   (oca),
        .out_err_o   (oea)
    );

    fip_result_acc #(
        .ACC_W     (20),
        .MAX_BEATS (4)
    ) dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (vb),
        .in_ready_o  (rb),
        .in_data_i   (din),
        .in_last_i   (in_last),
        .corr_i      (corr[19:0]),
        .out_valid_o (ovb),
        .out_ready_i (orb),
        .out_data_o  (odb),
        .out_cnt_o   (ocb),
        .out_err_o   (oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_din();
        for (int i = 0; i < 12; i++) din[i] = '0;
    endtask

    // Lanes 0,3,6,9 = 10,5,-3,4: beat sum 16.
    task automatic load16();
        clr_din();
        din[0] = 18'd10;
        din[3] = 18'd5;
        din[6] = -18'sd3;
        din[9] = 18'd4;
    endtask

    function automatic longint model_beat();
        longint s = 0;
        for (int i = 0; i < 12; i++) s += longint'($signed(din[i]));
        return s;
    endfunction

    task automatic send(input bit sel, input bit last);
        int n = 0;
        in_last = last;
        if (sel) vb = 1'b1;
        else     va = 1'b1;
        while (!(sel ? rb : ra) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_bad++;
            $display("FAIL send_ready: ready=0 after %0d cycles, want 1", n);
        end
        @(posedge clk); #1;
        va = 1'b0;
        vb = 1'b0;
        in_last = 1'bx;
        corr = 'x;
        for (int i = 0; i < 12; i++) din[i] = 'x;
    endtask

    task automatic wait_out(input bit sel);
        int n = 0;
        while (!(sel ? ovb : ova) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 20) begin
            n_bad++;
            $display("FAIL wait_out: out_valid=0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic drain(input bit sel);
        if (sel) orb = 1'b1;
        else     ora = 1'b1;
        @(posedge clk); #1;
        ora = 1'b0;
        orb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ova, oda, oca, oea} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: v=%b d=%0d c=%0d e=%b want all 0", ova, oda, oca, oea);
        end
        n_cmp++;
        if ({ovb, odb, ocb, oeb} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: v=%b d=%0d c=%0d e=%b want all 0", ovb, odb, ocb, oeb);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ra !== 1'b1 || rb !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: ra=%b rb=%b want 1 1", ra, rb);
        end
    endtask

    task automatic test_end2end();
        clr_din();
        din[0] = 18'd5;  din[1]  = 18'd1;
        din[3] = 18'd19; din[4]  = 18'd1;
        din[6] = 18'd41; din[7]  = 18'd1;
        din[9] = 18'd71; din[10] = 18'd1;
        corr = 32'd104;
        send(1'b0, 1'b1);
        n_cmp++;
        if (ova !== 1'b1 || oda !== 32'd36 || oca !== 9'd1 || oea !== 1'b0) begin
            n_bad++;
            $display("FAIL end2end: v=%b d=%0d c=%0d e=%b want 1 36 1 0",
                     ova, $signed(oda), oca, oea);
        end
        drain(1'b0);
    endtask

    task automatic test_multi();
        for (int b = 0; b < 3; b++) begin
            load16();
            corr = (b == 2) ? 32'd6 : 32'd12345;
            send(1'b0, b == 2);
        end
        wait_out(1'b0);
        n_cmp++;
        if (oda !== 32'd42 || oca !== 9'd3 || oea !== 1'b0) begin
            n_bad++;
            $display("FAIL multi: d=%0d c=%0d e=%b want 42 3 0", $signed(oda), oca, oea);
        end
        drain(1'b0);
    endtask

    task automatic test_backpressure();
        load16();
        corr = 32'd0;
        send(1'b0, 1'b1);
        load16();
        in_last = 1'b1;
        corr = 32'd0;
        va = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ova !== 1'b1 || oda !== 32'd16 || oca !== 9'd1 || ra !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: v=%b d=%0d c=%0d rdy=%b want 1 16 1 0",
                         k, ova, $signed(oda), oca, ra);
            end
        end
        ora = 1'b1;
        @(posedge clk); #1;
        ora = 1'b0;
        va = 1'b0;
        n_cmp++;
        if (ra !== 1'b1 || ova !== 1'b0) begin
            n_bad++;
            $display("FAIL release: rdy=%b v=%b want 1 0", ra, ova);
        end
    endtask

    task automatic test_wrap();
        logic [19:0] exp;
        longint s;
        clr_din();
        for (int i = 0; i < 4; i++) din[i] = 18'd131071;
        din[4] = 18'd3;
        s = model_beat();
        corr = 32'd0;
        send(1'b1, 1'b0);
        clr_din();
        din[0] = 18'd1;
        s += model_beat();
        corr = 32'd0;
        send(1'b1, 1'b1);
        exp = 20'(s);
        wait_out(1'b1);
        n_cmp++;
        if (odb !== exp || exp !== 20'h80000 || ocb !== 3'd2 || oeb !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap: d=%0d c=%0d e=%b want -524288 2 0", $signed(odb), ocb, oeb);
        end
        drain(1'b1);
    endtask

    task automatic test_force();
        for (int b = 0; b < 4; b++) begin
            load16();
            corr = 32'd99;
            send(1'b1, 1'b0);
        end
        n_cmp++;
        if (ovb !== 1'b1 || odb !== 20'd64 || ocb !== 3'd4 || oeb !== 1'b1) begin
            n_bad++;
            $display("FAIL force: v=%b d=%0d c=%0d e=%b want 1 64 4 1",
                     ovb, $signed(odb), ocb, oeb);
        end
        drain(1'b1);
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 2; b++) begin
            load16();
            corr = 32'd0;
            send(1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ova, oda, oca, oea} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: v=%b d=%0d c=%0d e=%b want all 0", ova, oda, oca, oea);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load16();
        corr = 32'd0;
        send(1'b0, 1'b1);
        wait_out(1'b0);
        n_cmp++;
        if (oda !== 32'd16 || oca !== 9'd1 || oea !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: d=%0d c=%0d e=%b want 16 1 0", $signed(oda), oca, oea);
        end
        drain(1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 15; t++) begin
            int nb;
            longint exp;
            logic [31:0] c;
            nb = $urandom_range(1, 6);
            exp = 0;
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 12; i++) din[i] = 18'($urandom);
                exp += model_beat();
                c = $urandom;
                corr = c;
                if (b == nb - 1) exp -= longint'($signed(c));
                send(1'b0, b == nb - 1);
            end
            wait_out(1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            n_cmp++;
            if (oda !== 32'(exp) || oca !== 9'(nb) || oea !== 1'b0) begin
                n_bad++;
                $display("FAIL random[%0d]: d=%h c=%0d e=%b want %h %0d 0",
                         t, oda, oca, oea, 32'(exp), nb);
            end
            drain(1'b0);
        end
    endtask

    initial begin
        va = 1'b0;
        vb = 1'b0;
        ora = 1'b0;
        orb = 1'b0;
        in_last = 1'b0;
        corr = '0;
        clr_din();
        test_reset();
        test_end2end();
        test_multi();
        test_backpressure();
        test_wrap();
        test_force();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
